// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size/sign codes, FSM
// states and per-size lane masks.
package lsu_pkg;

   localparam int DWORD_BYTES = 8;
   localparam int OFF_W       = $clog2(DWORD_BYTES);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } lsu_state_e;

   // Right-aligned byte mask for access size funct3[1:0].
   function automatic logic [63:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   size_mask = 64'h0000_0000_0000_00FF;
         2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
         2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   // Encoding and alignment faults; the range check lives in the top.
   function automatic logic access_fault(input logic       is_store,
                                         input logic [2:0] f3,
                                         input logic [OFF_W-1:0] off);
      logic flt;
      flt = (f3 == 3'b111) || (is_store && f3[2]);
      case (f3[1:0])
         2'b00:   flt = flt;
         2'b01:   flt = flt || off[0];
         2'b10:   flt = flt || (off[1:0] != 2'b00);
         default: flt = flt || (off != 3'b000);
      endcase
      access_fault = flt;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: load extract + sign/zero extend, and store
// merge of a right-aligned lane into an existing doubleword.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]       funct3_i,
   input  logic [OFF_W-1:0] off_i,
   input  logic [63:0]      rdata_i,
   input  logic [63:0]      wdata_i,
   output logic [63:0]      load_o,
   output logic [63:0]      merged_o
);

   logic [OFF_W+2:0] shamt_s;
   logic [63:0]      lane_s;
   logic [63:0]      mask_s;

   assign shamt_s = {off_i, 3'b000};
   assign lane_s  = rdata_i >> shamt_s;
   assign mask_s  = size_mask(funct3_i[1:0]) << shamt_s;

   // Load path: pick the lane at off and extend to 64 bits.
   always_comb begin
      load_o = 64'd0;
      case (funct3_i)
         F3_B:    load_o = {{56{lane_s[7]}},  lane_s[7:0]};
         F3_H:    load_o = {{48{lane_s[15]}}, lane_s[15:0]};
         F3_W:    load_o = {{32{lane_s[31]}}, lane_s[31:0]};
         F3_D:    load_o = rdata_i;
         F3_BU:   load_o = {56'd0, lane_s[7:0]};
         F3_HU:   load_o = {48'd0, lane_s[15:0]};
         F3_WU:   load_o = {32'd0, lane_s[31:0]};
         default: load_o = 64'd0;
      endcase
   end

   assign merged_o = (rdata_i & ~mask_s) | ((wdata_i << shamt_s) & mask_s);

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, read-modify-write for
// sub-doubleword stores, all memory strobes driven from registers.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_fault,
   output logic [63:0] mem_address,
   output logic [63:0] mem_write_data,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [63:0] mem_read_data
);

   lsu_state_e       state_q;
   logic             store_q;
   logic [2:0]       f3_q;
   logic [OFF_W-1:0] off_q;
   logic [63:0]      wdata_q;
   logic             req_ready_q;
   logic             resp_valid_q;
   logic [63:0]      resp_rdata_q;
   logic             resp_fault_q;
   logic [63:0]      mem_address_q;
   logic [63:0]      mem_write_data_q;
   logic             mem_write_q;
   logic             mem_read_q;

   logic             fault_s;
   logic [63:0]      load_s;
   logic [63:0]      merged_s;

   assign fault_s = access_fault(req_is_store, req_funct3, req_addr[OFF_W-1:0])
                    || (req_addr[63:OFF_W] >= 61'(MEM_WORDS));

   lsu_lane_align u_align (
      .funct3_i (f3_q),
      .off_i    (off_q),
      .rdata_i  (mem_read_data),
      .wdata_i  (wdata_q),
      .load_o   (load_s),
      .merged_o (merged_s)
   );

   // Request FSM with every output registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         store_q          <= 1'b0;
         f3_q             <= 3'b000;
         off_q            <= '0;
         wdata_q          <= 64'd0;
         req_ready_q      <= 1'b1;
         resp_valid_q     <= 1'b0;
         resp_rdata_q     <= 64'd0;
         resp_fault_q     <= 1'b0;
         mem_address_q    <= 64'd0;
         mem_write_data_q <= 64'd0;
         mem_write_q      <= 1'b0;
         mem_read_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  store_q       <= req_is_store;
                  f3_q          <= req_funct3;
                  off_q         <= req_addr[OFF_W-1:0];
                  wdata_q       <= req_wdata;
                  req_ready_q   <= 1'b0;
                  mem_address_q <= {req_addr[63:OFF_W], 3'b000};
                  if (fault_s) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= 64'd0;
                     resp_fault_q <= 1'b1;
                  end else if (req_is_store && (req_funct3 == F3_D)) begin
                     state_q          <= WRITE;
                     mem_write_q      <= 1'b1;
                     mem_write_data_q <= req_wdata;
                  end else begin
                     state_q    <= READ;
                     mem_read_q <= 1'b1;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            READ: begin
               mem_read_q <= 1'b0;
               if (store_q) begin
                  state_q          <= WRITE;
                  mem_write_q      <= 1'b1;
                  mem_write_data_q <= merged_s;
               end else begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= load_s;
                  resp_fault_q <= 1'b0;
               end
            end
            WRITE: begin
               mem_write_q  <= 1'b0;
               state_q      <= RESP;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= 64'd0;
               resp_fault_q <= 1'b0;
            end
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
               end else begin
                  state_q <= RESP;
               end
            end
            default: begin
               state_q      <= IDLE;
               req_ready_q  <= 1'b1;
               resp_valid_q <= 1'b0;
               mem_write_q  <= 1'b0;
               mem_read_q   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready      = req_ready_q;
   assign resp_valid     = resp_valid_q;
   assign resp_rdata     = resp_rdata_q;
   assign resp_fault     = resp_fault_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_write_data_q;
   assign mem_write      = mem_write_q;
   assign mem_read       = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 1024-doubleword memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_is_store;
   logic [2:0]  req_funct3;
   logic [63:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_fault;
   logic [63:0] resp_rdata;
   logic [63:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_write, mem_read;

   logic [63:0] mem [0:1023];
   int          rd_cnt = 0, wr_cnt = 0;
   logic        both_seen = 1'b0;
   logic [63:0] last_raddr = 64'd0, last_wdata = 64'd0;
   int          n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(1024)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
   );

   assign mem_read_data = mem[mem_address[12:3]];

   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_address[12:3]] <= mem_write_data;
         wr_cnt     <= wr_cnt + 1;
         last_wdata <= mem_write_data;
      end
      if (mem_read) begin
         rd_cnt     <= rd_cnt + 1;
         last_raddr <= mem_address;
      end
      if (mem_read && mem_write) both_seen <= 1'b1;
   end

   task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, output logic [63:0] rd, output logic flt,
                         output int lat, output int drd, output int dwr);
      int rd0, wr0;
      rd0 = rd_cnt; wr0 = wr_cnt;
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = resp_rdata; flt = resp_fault;
      @(posedge clk); #1;
      drd = rd_cnt - rd0; dwr = wr_cnt - wr0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_checks += 8;
      if (req_ready !== 1'b1)      begin n_fail++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
      if (resp_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
      if (resp_rdata !== 64'd0)    begin n_fail++; $display("FAIL rst_resp_rdata got %h exp 0", resp_rdata); end
      if (resp_fault !== 1'b0)     begin n_fail++; $display("FAIL rst_resp_fault got %b exp 0", resp_fault); end
      if (mem_read !== 1'b0)       begin n_fail++; $display("FAIL rst_mem_read got %b exp 0", mem_read); end
      if (mem_write !== 1'b0)      begin n_fail++; $display("FAIL rst_mem_write got %b exp 0", mem_write); end
      if (mem_address !== 64'd0)   begin n_fail++; $display("FAIL rst_mem_address got %h exp 0", mem_address); end
      if (mem_write_data !== 64'd0) begin n_fail++; $display("FAIL rst_mem_wdata got %h exp 0", mem_write_data); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3 [4];
      logic [63:0] ad [4];
      logic [63:0] ex [4];
      logic [63:0] rd;
      logic        flt;
      int          lat, drd, dwr;
      f3[0] = 3'b000; ad[0] = 64'h17; ex[0] = 64'hFFFF_FFFF_FFFF_FF88;
      f3[1] = 3'b101; ad[1] = 64'h16; ex[1] = 64'h0000_0000_0000_8877;
      f3[2] = 3'b110; ad[2] = 64'h14; ex[2] = 64'h0000_0000_8877_6655;
      f3[3] = 3'b010; ad[3] = 64'h10; ex[3] = 64'h0000_0000_4433_2211;
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, f3[i], ad[i], 64'd0, rd, flt, lat, drd, dwr);
         n_checks += 6;
         if (rd !== ex[i])  begin n_fail++; $display("FAIL load%0d_rdata got %h exp %h", i, rd, ex[i]); end
         if (flt !== 1'b0)  begin n_fail++; $display("FAIL load%0d_fault got %b exp 0", i, flt); end
         if (lat !== 2)     begin n_fail++; $display("FAIL load%0d_latency got %0d exp 2", i, lat); end
         if (drd !== 1)     begin n_fail++; $display("FAIL load%0d_reads got %0d exp 1", i, drd); end
         if (dwr !== 0)     begin n_fail++; $display("FAIL load%0d_writes got %0d exp 0", i, dwr); end
         if (last_raddr !== 64'h10) begin n_fail++; $display("FAIL load%0d_addr got %h exp 10", i, last_raddr); end
      end
   endtask

   task automatic test_stores();
      logic [63:0] rd;
      logic        flt;
      int          lat, drd, dwr;
      do_req(1'b1, 3'b000, 64'h13, 64'h1234_5678_9ABC_DEAB, rd, flt, lat, drd, dwr);
      n_checks += 6;
      if (lat !== 3)     begin n_fail++; $display("FAIL sb_latency got %0d exp 3", lat); end
      if (drd !== 1)     begin n_fail++; $display("FAIL sb_reads got %0d exp 1", drd); end
      if (dwr !== 1)     begin n_fail++; $display("FAIL sb_writes got %0d exp 1", dwr); end
      if (rd !== 64'd0)  begin n_fail++; $display("FAIL sb_rdata got %h exp 0", rd); end
      if (last_wdata !== 64'h8877_6655_AB33_2211) begin n_fail++; $display("FAIL sb_wdata got %h exp 88776655ab332211", last_wdata); end
      if (mem[2] !== 64'h8877_6655_AB33_2211) begin n_fail++; $display("FAIL sb_mem got %h exp 88776655ab332211", mem[2]); end
      do_req(1'b0, 3'b011, 64'h10, 64'd0, rd, flt, lat, drd, dwr);
      n_checks += 1;
      if (rd !== 64'h8877_6655_AB33_2211) begin n_fail++; $display("FAIL ld_after_sb got %h exp 88776655ab332211", rd); end
      do_req(1'b1, 3'b011, 64'h18, 64'hCAFE_F00D_DEAD_BEEF, rd, flt, lat, drd, dwr);
      n_checks += 4;
      if (lat !== 2)     begin n_fail++; $display("FAIL sd_latency got %0d exp 2", lat); end
      if (drd !== 0)     begin n_fail++; $display("FAIL sd_reads got %0d exp 0", drd); end
      if (dwr !== 1)     begin n_fail++; $display("FAIL sd_writes got %0d exp 1", dwr); end
      if (mem[3] !== 64'hCAFE_F00D_DEAD_BEEF) begin n_fail++; $display("FAIL sd_mem got %h exp cafef00ddeadbeef", mem[3]); end
   endtask

   task automatic test_faults();
      logic        st [5];
      logic [2:0]  f3 [5];
      logic [63:0] ad [5];
      logic [63:0] rd;
      logic        flt;
      int          lat, drd, dwr;
      st[0] = 1'b0; f3[0] = 3'b010; ad[0] = 64'h12;
      st[1] = 1'b1; f3[1] = 3'b011; ad[1] = 64'h14;
      st[2] = 1'b0; f3[2] = 3'b011; ad[2] = 64'h2000;
      st[3] = 1'b1; f3[3] = 3'b100; ad[3] = 64'h10;
      st[4] = 1'b0; f3[4] = 3'b111; ad[4] = 64'h10;
      for (int i = 0; i < 5; i++) begin
         do_req(st[i], f3[i], ad[i], 64'hFFFF_FFFF_FFFF_FFFF, rd, flt, lat, drd, dwr);
         n_checks += 5;
         if (flt !== 1'b1)  begin n_fail++; $display("FAIL fault%0d_flag got %b exp 1", i, flt); end
         if (rd !== 64'd0)  begin n_fail++; $display("FAIL fault%0d_rdata got %h exp 0", i, rd); end
         if (lat !== 1)     begin n_fail++; $display("FAIL fault%0d_latency got %0d exp 1", i, lat); end
         if (drd !== 0)     begin n_fail++; $display("FAIL fault%0d_reads got %0d exp 0", i, drd); end
         if (dwr !== 0)     begin n_fail++; $display("FAIL fault%0d_writes got %0d exp 0", i, dwr); end
      end
   endtask

   task automatic test_back_to_back();
      int rd0, lat;
      resp_ready = 1'b0;
      req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b011; req_addr = 64'h10; req_wdata = 64'd0;
      @(posedge clk); #1;
      req_funct3 = 3'b000;
      lat = 1;
      while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      rd0 = rd_cnt;
      for (int i = 0; i < 5; i++) begin
         n_checks += 3;
         if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL stall%0d_valid got %b exp 1", i, resp_valid); end
         if (resp_rdata !== 64'h8877_6655_AB33_2211) begin n_fail++; $display("FAIL stall%0d_rdata got %h exp 88776655ab332211", i, resp_rdata); end
         if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall%0d_req_ready got %b exp 0", i, req_ready); end
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks += 4;
      if (rd_cnt !== rd0)      begin n_fail++; $display("FAIL stall_no_accept got %0d reads exp %0d", rd_cnt, rd0); end
      if (req_ready !== 1'b1)  begin n_fail++; $display("FAIL hs_req_ready got %b exp 1", req_ready); end
      if (mem_read !== 1'b0)   begin n_fail++; $display("FAIL hs_early_read got %b exp 0", mem_read); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (mem_read !== 1'b1)   begin n_fail++; $display("FAIL next_accept got %b exp 1", mem_read); end
      lat = 1;
      while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      n_checks += 1;
      if (resp_rdata !== 64'h11) begin n_fail++; $display("FAIL next_rdata got %h exp 11", resp_rdata); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int wr0;
      wr0 = wr_cnt;
      req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b001; req_addr = 64'h1A; req_wdata = 64'hBEEF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_checks += 1;
      if (mem_read !== 1'b1) begin n_fail++; $display("FAIL sh_in_read got %b exp 1", mem_read); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks += 4;
      if (req_ready !== 1'b1)  begin n_fail++; $display("FAIL abort_req_ready got %b exp 1", req_ready); end
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_resp_valid got %b exp 0", resp_valid); end
      if (mem_write !== 1'b0)  begin n_fail++; $display("FAIL abort_mem_write got %b exp 0", mem_write); end
      if (mem_read !== 1'b0)   begin n_fail++; $display("FAIL abort_mem_read got %b exp 0", mem_read); end
      repeat (4) @(posedge clk);
      #1;
      n_checks += 2;
      if (wr_cnt !== wr0) begin n_fail++; $display("FAIL abort_writes got %0d exp %0d", wr_cnt, wr0); end
      if (mem[3] !== 64'hCAFE_F00D_DEAD_BEEF) begin n_fail++; $display("FAIL abort_mem got %h exp cafef00ddeadbeef", mem[3]); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
      mem[2] = 64'h8877_6655_4433_2211;
      rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
      req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b1;
      test_reset();
      test_loads();
      test_stores();
      test_faults();
      test_back_to_back();
      test_reset_mid();
      n_checks += 1;
      if (both_seen !== 1'b0) begin n_fail++; $display("FAIL rd_wr_overlap got %b exp 0", both_seen); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
